jtag_tap_multi: RTL

- Parametrised IEEE 1149.1-style TAP for the JTAG top. Successor to the fixed single-chain debug TAP.
- Contains the 16-state TAP FSM, an instruction register of configurable length, BYPASS and IDCODE registers, and NUM_DR user data registers.
- Each user register has a parallel capture/update interface, so core-side debug logic (memory access, run-control) can attach one channel per register.
- TCK is the only clock.

---
 rtl/jtag_pkg.sv | 58 +++++
 rtl/jtag_tap_fsm.sv | 75 +++++++
 rtl/jtag_tap_multi.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared types and helpers for the multi-register JTAG TAP: state encoding,
// instruction constants and the instruction-to-register decode.
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam int unsigned INSTR_BYPASS    = 32'd0;
    localparam int unsigned INSTR_IDCODE    = 32'd1;
    localparam int unsigned INSTR_USER_BASE = 32'd2;

    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_IDCODE = 2'd1,
        SEL_USER   = 2'd2
    } dr_kind_t;

    typedef struct packed {
        dr_kind_t    kind;
        logic [15:0] idx;
    } dr_sel_t;

    // Map an instruction onto the data register it selects. Anything that is
    // not IDCODE or a populated user slot (including all-ones) is BYPASS.
    function automatic dr_sel_t decode_instr(input logic [31:0] instr,
                                             input int unsigned num_dr);
        dr_sel_t sel;
        sel.kind = SEL_BYPASS;
        sel.idx  = 16'd0;
        if (instr == INSTR_IDCODE) begin
            sel.kind = SEL_IDCODE;
        end else if ((instr >= INSTR_USER_BASE) &&
                     ((instr - INSTR_USER_BASE) < num_dr)) begin
            sel.kind = SEL_USER;
            sel.idx  = 16'(instr - INSTR_USER_BASE);
        end else begin
            sel.kind = SEL_BYPASS;
        end
        return sel;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller. Provides the current state plus decode flags for
// the current state (actions on the leaving edge) and for the next state
// (used to pre-compute registered outputs).
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_i,
    input  logic       tms_i,
    output tap_state_t state_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       capture_ir_o,
    output logic       shift_ir_o,
    output logic       update_ir_o,
    output logic       enter_capture_dr_o,
    output logic       enter_shift_dr_o,
    output logic       enter_shift_ir_o,
    output logic       enter_update_dr_o,
    output logic       enter_tlr_o
);

    tap_state_t state_q;
    tap_state_t state_d;

    // State register with synchronous active-low reset.
    always_ff @(posedge tck_i) begin
        if (!trst_i) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard TMS-driven next-state function.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms_i ? SELECT_DR  : RUN_TEST_IDLE;
            SELECT_DR:        state_d = tms_i ? SELECT_IR  : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms_i ? EXIT1_DR   : SHIFT_DR;
            SHIFT_DR:         state_d = tms_i ? EXIT1_DR   : SHIFT_DR;
            EXIT1_DR:         state_d = tms_i ? UPDATE_DR  : PAUSE_DR;
            PAUSE_DR:         state_d = tms_i ? EXIT2_DR   : PAUSE_DR;
            EXIT2_DR:         state_d = tms_i ? UPDATE_DR  : SHIFT_DR;
            UPDATE_DR:        state_d = tms_i ? SELECT_DR  : RUN_TEST_IDLE;
            SELECT_IR:        state_d = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms_i ? EXIT1_IR   : SHIFT_IR;
            SHIFT_IR:         state_d = tms_i ? EXIT1_IR   : SHIFT_IR;
            EXIT1_IR:         state_d = tms_i ? UPDATE_IR  : PAUSE_IR;
            PAUSE_IR:         state_d = tms_i ? EXIT2_IR   : PAUSE_IR;
            EXIT2_IR:         state_d = tms_i ? UPDATE_IR  : SHIFT_IR;
            UPDATE_IR:        state_d = tms_i ? SELECT_DR  : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    // Decode flags for the current and upcoming state.
    always_comb begin
        capture_dr_o       = (state_q == CAPTURE_DR);
        shift_dr_o         = (state_q == SHIFT_DR);
        capture_ir_o       = (state_q == CAPTURE_IR);
        shift_ir_o         = (state_q == SHIFT_IR);
        update_ir_o        = (state_q == UPDATE_IR);
        enter_capture_dr_o = (state_d == CAPTURE_DR);
        enter_shift_dr_o   = (state_d == SHIFT_DR);
        enter_shift_ir_o   = (state_d == SHIFT_IR);
        enter_update_dr_o  = (state_d == UPDATE_DR);
        enter_tlr_o        = (state_d == TEST_LOGIC_RESET);
    end

    assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_multi.sv
// Parametrised TAP with IR, BYPASS, IDCODE and NUM_DR user data registers.
// Each user register has a parallel capture/update channel to core logic.
// All outputs come straight from flops clocked by tck.
module jtag_tap_multi
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
    parameter int unsigned NUM_DR     = 2,
    parameter int unsigned DR_WIDTH   = 32
) (
    input  logic                         tck,
    input  logic                         trst,
    input  logic                         tms,
    input  logic                         tdi,
    output logic                         tdo,
    output logic                         tdo_en,
    output logic [3:0]                   tap_state,
    output logic [IR_WIDTH-1:0]          ir_out,
    input  logic [NUM_DR*DR_WIDTH-1:0]   dr_capture_data,
    output logic [DR_WIDTH-1:0]          dr_update_data,
    output logic [NUM_DR-1:0]            dr_update_valid,
    output logic [NUM_DR-1:0]            dr_capture_strobe
);

    tap_state_t state_s;
    logic capture_dr_s, shift_dr_s, capture_ir_s, shift_ir_s, update_ir_s;
    logic enter_capture_dr_s, enter_shift_dr_s, enter_shift_ir_s;
    logic enter_update_dr_s, enter_tlr_s;

    jtag_tap_fsm u_fsm (
        .tck_i              (tck),
        .trst_i             (trst),
        .tms_i              (tms),
        .state_o            (state_s),
        .capture_dr_o       (capture_dr_s),
        .shift_dr_o         (shift_dr_s),
        .capture_ir_o       (capture_ir_s),
        .shift_ir_o         (shift_ir_s),
        .update_ir_o        (update_ir_s),
        .enter_capture_dr_o (enter_capture_dr_s),
        .enter_shift_dr_o   (enter_shift_dr_s),
        .enter_shift_ir_o   (enter_shift_ir_s),
        .enter_update_dr_o  (enter_update_dr_s),
        .enter_tlr_o        (enter_tlr_s)
    );

    logic [IR_WIDTH-1:0]               ir_q, ir_d;
    logic [IR_WIDTH-1:0]               ir_shift_q, ir_shift_d;
    logic                              bypass_q, bypass_d;
    logic [31:0]                       idcode_shift_q, idcode_shift_d;
    logic [NUM_DR-1:0][DR_WIDTH-1:0]   user_shift_q, user_shift_d;
    logic [DR_WIDTH-1:0]               upd_data_q, upd_data_d;
    logic [NUM_DR-1:0]                 upd_valid_q, upd_valid_d;
    logic [NUM_DR-1:0]                 cap_strobe_q, cap_strobe_d;
    logic                              tdo_q, tdo_d;
    logic                              tdo_en_q, tdo_en_d;

    dr_sel_t                           sel_s;
    logic [NUM_DR-1:0]                 user_oh_s;

    // Decode the active instruction into a register select and user one-hot.
    always_comb begin
        sel_s = decode_instr(32'(ir_q), NUM_DR);
        for (int k = 0; k < int'(NUM_DR); k++) begin
            user_oh_s[k] = (sel_s.kind == SEL_USER) && (sel_s.idx == 16'(k));
        end
    end

    // Instruction register: capture, shift, update, and IDCODE on TLR entry.
    always_comb begin
        ir_shift_d = ir_shift_q;
        if (capture_ir_s) begin
            ir_shift_d = IR_WIDTH'(2'b01);
        end else if (shift_ir_s) begin
            ir_shift_d = ir_shift_q >> 1;
            ir_shift_d[IR_WIDTH-1] = tdi;
        end else begin
            ir_shift_d = ir_shift_q;
        end

        if (enter_tlr_s) begin
            ir_d = IR_WIDTH'(INSTR_IDCODE);
        end else if (update_ir_s) begin
            ir_d = ir_shift_q;
        end else begin
            ir_d = ir_q;
        end
    end

    // Data registers: only the selected one captures or shifts.
    always_comb begin
        bypass_d       = bypass_q;
        idcode_shift_d = idcode_shift_q;
        user_shift_d   = user_shift_q;

        if (capture_dr_s && (sel_s.kind == SEL_BYPASS)) begin
            bypass_d = 1'b0;
        end else if (shift_dr_s && (sel_s.kind == SEL_BYPASS)) begin
            bypass_d = tdi;
        end else begin
            bypass_d = bypass_q;
        end

        if (capture_dr_s && (sel_s.kind == SEL_IDCODE)) begin
            idcode_shift_d = IDCODE_VAL;
        end else if (shift_dr_s && (sel_s.kind == SEL_IDCODE)) begin
            idcode_shift_d = {tdi, idcode_shift_q[31:1]};
        end else begin
            idcode_shift_d = idcode_shift_q;
        end

        for (int k = 0; k < int'(NUM_DR); k++) begin
            if (capture_dr_s && user_oh_s[k]) begin
                user_shift_d[k] = dr_capture_data[k*DR_WIDTH +: DR_WIDTH];
            end else if (shift_dr_s && user_oh_s[k]) begin
                user_shift_d[k] = user_shift_q[k] >> 1;
                user_shift_d[k][DR_WIDTH-1] = tdi;
            end else begin
                user_shift_d[k] = user_shift_q[k];
            end
        end
    end

    // Core-side strobes and update data, timed against the upcoming state so
    // the registered pulses line up with Capture-DR and the cycle after the
    // Update-DR entry edge.
    always_comb begin
        cap_strobe_d = enter_capture_dr_s ? user_oh_s : {NUM_DR{1'b0}};
        upd_valid_d  = enter_update_dr_s  ? user_oh_s : {NUM_DR{1'b0}};
        upd_data_d   = upd_data_q;
        for (int k = 0; k < int'(NUM_DR); k++) begin
            if (enter_update_dr_s && user_oh_s[k]) begin
                upd_data_d = user_shift_q[k];
            end else begin
                upd_data_d = upd_data_d;
            end
        end
    end

    // TDO pre-computed from next-cycle register contents so it is a flop.
    always_comb begin
        tdo_d    = 1'b0;
        tdo_en_d = enter_shift_ir_s | enter_shift_dr_s;
        if (enter_shift_ir_s) begin
            tdo_d = ir_shift_d[0];
        end else if (enter_shift_dr_s) begin
            case (sel_s.kind)
                SEL_IDCODE: tdo_d = idcode_shift_d[0];
                SEL_USER: begin
                    for (int k = 0; k < int'(NUM_DR); k++) begin
                        tdo_d = tdo_d | (user_oh_s[k] & user_shift_d[k][0]);
                    end
                end
                default:    tdo_d = bypass_d;
            endcase
        end else begin
            tdo_d = 1'b0;
        end
    end

    // Register bank with synchronous active-low reset; reset abandons any scan.
    always_ff @(posedge tck) begin
        if (!trst) begin
            ir_q           <= IR_WIDTH'(INSTR_IDCODE);
            ir_shift_q     <= {IR_WIDTH{1'b0}};
            bypass_q       <= 1'b0;
            idcode_shift_q <= 32'd0;
            user_shift_q   <= {(NUM_DR*DR_WIDTH){1'b0}};
            upd_data_q     <= {DR_WIDTH{1'b0}};
            upd_valid_q    <= {NUM_DR{1'b0}};
            cap_strobe_q   <= {NUM_DR{1'b0}};
            tdo_q          <= 1'b0;
            tdo_en_q       <= 1'b0;
        end else begin
            ir_q           <= ir_d;
            ir_shift_q     <= ir_shift_d;
            bypass_q       <= bypass_d;
            idcode_shift_q <= idcode_shift_d;
            user_shift_q   <= user_shift_d;
            upd_data_q     <= upd_data_d;
            upd_valid_q    <= upd_valid_d;
            cap_strobe_q   <= cap_strobe_d;
            tdo_q          <= tdo_d;
            tdo_en_q       <= tdo_en_d;
        end
    end

    assign tdo               = tdo_q;
    assign tdo_en            = tdo_en_q;
    assign tap_state         = state_s;
    assign ir_out            = ir_q;
    assign dr_update_data    = upd_data_q;
    assign dr_update_valid   = upd_valid_q;
    assign dr_capture_strobe = cap_strobe_q;

endmodule
